// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester data-memory arbiter.
package mem_arbiter_pkg;

    localparam int WAIT_CYCLES_DEF = 4;
    localparam int ADDR_W_DEF      = 10;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant: when both request, the side not granted last wins.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    output logic grant_b
);

    // Reset value 1 ("B went last") makes A the first winner.
    logic last_b;

    always_comb begin
        grant_b = req_b && (!req_a || !last_b);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b <= 1'b1;
        end else if (update) begin
            last_b <= grant_b;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates requesters A (pipeline) and B (DMA/debug) onto one fixed-latency
// data-memory port. Handshake: req/we/addr/wdata held until a one-cycle ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [31:0]       a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ready,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ready,
    output logic [31:0]       b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output state_t            state_dbg
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic             lat_b;
    logic             grant_b;
    logic             any_req;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             unused_addr_bits;

    assign any_req   = a_req || b_req;
    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;

    // Byte offset and bits above the word index are dropped on purpose.
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_a   (a_req),
        .req_b   (b_req),
        .update  ((state == IDLE) && any_req),
        .grant_b (grant_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_b     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            a_ready   <= 1'b0;
            b_ready   <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= WAIT;
                        cnt       <= CNT_W'(WAIT_CYCLES - 1);
                        lat_we    <= sel_we;
                        lat_b     <= grant_b;
                        mem_addr  <= sel_addr[ADDR_W+1:2];
                        mem_wdata <= sel_wdata;
                        mem_re    <= !sel_we;
                        mem_we    <= sel_we && (WAIT_CYCLES == 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state   <= RESP;
                        mem_re  <= 1'b0;
                        mem_we  <= 1'b0;
                        a_ready <= !lat_b;
                        b_ready <= lat_b;
                        if (!lat_we) begin
                            if (lat_b) begin
                                b_rdata <= mem_rdata;
                            end else begin
                                a_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt    <= cnt - 1'b1;
                        // Write strobe lands only on the last wait cycle.
                        mem_we <= lat_we && (cnt == CNT_W'(1));
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    a_ready <= 1'b0;
                    b_ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a behavioural data memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W  = 4;
    localparam int AW = 10;
    localparam int EW = 65;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0]   a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic          a_ready, b_ready, mem_we, mem_re, busy;
    logic [31:0]   a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    state_t        state_dbg;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          preload = 1'b1;
    int            we_cnt = 0;
    logic [31:0]   last_we_addr = '0;
    logic [31:0]   last_we_data = '0;

    logic [EW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic          watch_en = 1'b0;
    logic [31:0]   watch_addr = '0;

    mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / memory ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            mem[5]  <= 32'hDEADBEEF;
            mem[6]  <= 32'h0606_0606;
            mem[9]  <= 32'h0909_0909;
            mem[10] <= 32'h0A0A_0A0A;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
            last_we_addr  <= 32'(mem_addr);
            last_we_data  <= mem_wdata;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst && (a_ready || b_ready)) begin
            check("single_ready", 32'(a_ready & b_ready), 32'h0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: a_ready=%b b_ready=%b with nothing expected", a_ready, b_ready);
            end else begin
                e = exp_q.pop_front();
                check("ready_port_b", 32'(b_ready), 32'(e[64]));
                check("rdata", e[64] ? b_rdata : a_rdata, e[63:32]);
                check("ready_cycle", 32'(cyc), e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (watch_en && state_dbg == WAIT) begin
            check("wait_mem_addr", 32'(mem_addr), watch_addr);
            check("wait_mem_re", 32'(mem_re), 32'h1);
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xact(input bit is_b, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input bit push);
        bit got;
        got = 1'b0;
        @(negedge clk);
        if (push) exp_q.push_back({is_b, exp_rd, 32'(cyc + 1 + W)});
        if (is_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = is_b ? b_ready : a_ready;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: requester %s addr %h got no ready", is_b ? "B" : "A", addr);
        end
        if (is_b) b_req = 1'b0; else a_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int w0;
        bit drained;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_a_ready", 32'(a_ready), 32'h0);
        check("rst_b_ready", 32'(b_ready), 32'h0);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_a_rdata", a_rdata, 32'h0);
        check("rst_b_rdata", b_rdata, 32'h0);
        preload = 1'b0;
        rst = 1'b1;
        idle(2);

        // Read A word 5.
        watch_addr = 32'h5; watch_en = 1'b1;
        xact(1'b0, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b1);
        watch_en = 1'b0;
        idle(2);

        // Write B word 8; b_rdata must stay at its reset value.
        w0 = we_cnt;
        xact(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b1);
        idle(1);
        check("write_edges", 32'(we_cnt - w0), 32'h1);
        check("write_addr", last_we_addr, 32'h8);
        check("write_data", last_we_data, 32'h12345678);
        check("mem_word8", mem[8], 32'h12345678);
        check("idle_mem_addr_hold", 32'(mem_addr), 32'h8);
        idle(1);

        // Address masking.
        watch_addr = 32'h5; watch_en = 1'b1;
        xact(1'b0, 1'b0, 32'h0000_1017, 32'h0, 32'hDEADBEEF, 1'b1);
        idle(2);

        // Address change while the access is in flight.
        fork
            xact(1'b0, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b1);
            begin
                repeat (2) @(negedge clk);
                a_addr = 32'h18;
            end
        join
        watch_en = 1'b0;
        idle(2);

        // Read back B word 8 (leaves B as last grant).
        xact(1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b1);
        idle(2);

        // Contention: A, B, A, B at WAIT_CYCLES+2 spacing.
        @(negedge clk);
        c = cyc;
        exp_q.push_back({1'b0, 32'hDEADBEEF, 32'(c + 6)});
        exp_q.push_back({1'b1, 32'h12345678, 32'(c + 12)});
        exp_q.push_back({1'b0, 32'h0909_0909, 32'(c + 18)});
        exp_q.push_back({1'b1, 32'h0A0A_0A0A, 32'(c + 24)});
        fork
            begin
                xact(1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
                xact(1'b0, 1'b0, 32'h24, 32'h0, 32'h0, 1'b0);
            end
            begin
                xact(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
                xact(1'b1, 1'b0, 32'h28, 32'h0, 32'h0, 1'b0);
            end
        join
        idle(3);

        // Reset while a write of word 9 is in WAIT with counter 2.
        w0 = we_cnt;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h24; a_wdata = 32'hFFFF_0000;
        repeat (2) @(negedge clk);
        check("pre_abort_state", 32'(state_dbg), 32'(WAIT));
        rst = 1'b0;
        a_req = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_a_ready", 32'(a_ready), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(5);
        check("abort_no_write", 32'(we_cnt - w0), 32'h0);
        check("abort_word9", mem[9], 32'h0909_0909);
        check("post_rst_idle", 32'(busy), 32'h0);
        check("post_rst_a_rdata", a_rdata, 32'h0);

        // Both request right after reset: A must win first.
        @(negedge clk);
        c = cyc;
        exp_q.push_back({1'b0, 32'h0909_0909, 32'(c + 6)});
        exp_q.push_back({1'b1, 32'h0A0A_0A0A, 32'(c + 12)});
        fork
            xact(1'b0, 1'b0, 32'h24, 32'h0, 32'h0, 1'b0);
            xact(1'b1, 1'b0, 32'h28, 32'h0, 32'h0, 1'b0);
        join
        idle(3);

        drained = 1'b0;
        for (int i = 0; i < 50 && !drained; i++) begin
            if (exp_q.size() == 0) drained = 1'b1;
            else @(negedge clk);
        end
        if (!drained) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected responses never arrived", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 4: memory wait cycles per access, legal range 1..15.
REQ-002 Parameter ADDR_W, default 10: word-index width; memory depth is 2**ADDR_W words.
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Ports: a_req input 1, a_we input 1, a_addr input 32 (byte address), a_wdata input 32  requester A (pipeline MEM stage).
REQ-006 Ports: a_ready output 1, a_rdata output 32  requester A completion pulse and read data.
REQ-007 Ports: b_req, b_we, b_addr, b_wdata, b_ready, b_rdata  requester B (DMA/debug), same widths and directions as A.
REQ-008 Ports: mem_addr output ADDR_W, mem_wdata output 32, mem_we output 1, mem_re output 1, mem_rdata input 32  shared data-memory port.
REQ-009 Port: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-010 FSM states SHALL be IDLE, WAIT, RESP.
REQ-011 In IDLE with at least one req high, the block SHALL grant, latch the granted requester's we/addr/wdata, load wait counter with WAIT_CYCLES-1, and enter WAIT.
REQ-012 Single pending request SHALL be granted directly.
REQ-013 Both requests pending in IDLE SHALL be resolved round-robin: grant the requester not granted last; after reset, A wins first.
REQ-014 In WAIT, mem_addr SHALL equal latched addr[ADDR_W+1:2]; addr bits [1:0] and bits above ADDR_W+1 are ignored.
REQ-015 In WAIT, mem_re SHALL be high for every cycle of a read; mem_we SHALL be high only in the final WAIT cycle (counter = 0) of a write, giving exactly one write edge.
REQ-016 In WAIT, the counter SHALL decrement each cycle; at counter = 0, go to RESP, and for a read register mem_rdata into the granted requester's rdata.
REQ-017 In RESP, the granted requester's ready SHALL be high for exactly one cycle; the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency: a request sampled at edge N SHALL see ready high in the cycle after edge N+WAIT_CYCLES.
REQ-019 Requesters SHALL hold req/we/addr/wdata until ready; a req still high in IDLE after RESP SHALL be treated as a new request.
REQ-020 Changes to req/addr/wdata during WAIT or RESP SHALL NOT affect the access in flight.
REQ-021 a_rdata/b_rdata SHALL hold their last read value until the next read completes for that requester; writes SHALL NOT change them.
REQ-022 Outside WAIT, mem_re and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold the last latched values.
REQ-023 Ready of the non-granted requester SHALL stay 0.

Reset
REQ-024 On rst low, the FSM SHALL go to IDLE immediately, regardless of clock.
REQ-025 During reset: counter, latched registers, a_rdata, b_rdata, mem_addr, mem_wdata = 0; mem_re, mem_we, a_ready, b_ready, busy = 0; round-robin pointer SHALL favour A.
REQ-026 Reset during WAIT SHALL abort the access with no write and no ready pulse; first grant after reset release SHALL need a fresh sampled req.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, WAIT, RESP), WAIT_CYCLES default and ADDR_W default.
REQ-028 Two-way round-robin grant logic SHALL be a sub-module named rr_arbiter2 (inputs req_a, req_b, update; output grant_b; internal last-grant flop).

Verification
REQ-029 Read A only: preload word 5 = 32'hDEADBEEF, a_req=1, a_we=0, a_addr=32'h14 -> single a_ready 5 cycles after sample edge (WAIT_CYCLES=4), a_rdata=32'hDEADBEEF, b_ready stays 0.
REQ-030 Write B: b_we=1, b_addr=32'h20, b_wdata=32'h12345678 -> mem_we high exactly one cycle with mem_addr=8; a later read of 32'h20 returns 32'h12345678.
REQ-031 Contention: a_req and b_req rise together and stay high -> grants A, B, A, B; each ready pulse separated by WAIT_CYCLES+2 cycles.
REQ-032 Address masking: a_addr=32'h0000_1017 -> mem_addr=10'h005.
REQ-033 Reset mid-access: write in flight, rst low at WAIT counter 2 -> mem_we never asserted, target word unchanged, busy=0 immediately, no ready.
REQ-034 Input change in WAIT: a_addr switches 32'h14->32'h18 mid-access -> mem_addr stays 5 for the whole access.
